// File: rtl/ref_pattern_pkg.sv
// Shared definitions for the reference pattern generator: mode encodings,
// PRBS7 polynomial taps and the per-channel seed.
package ref_pattern_pkg;

   typedef enum logic [2:0] {
      MODE_ZERO   = 3'b000,
      MODE_ONE    = 3'b001,
      MODE_TOGGLE = 3'b010,
      MODE_PULSE  = 3'b011,
      MODE_PRBS   = 3'b100,
      MODE_SQUARE = 3'b101
   } mode_e;

   // x^7 + x^6 + 1, shift-left Fibonacci form; the output is the top bit
   localparam int PRBS_W       = 7;
   localparam int PRBS_TAP_A   = 6;
   localparam int PRBS_TAP_B   = 5;
   localparam int PRBS_OUT_BIT = 6;

   function automatic logic [PRBS_W-1:0] prbs_seed(input int unsigned ch);
      return PRBS_W'(ch + 1);
   endfunction

   function automatic logic [PRBS_W-1:0] prbs_next(input logic [PRBS_W-1:0] s);
      return {s[PRBS_W-2:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
   endfunction

endpackage

// File: rtl/ref_pattern_ch.sv
// One reference channel: free-running PRBS7 LFSR, mode selector and the
// registered output bit. Frame-level decisions arrive from the shared counter.
module ref_pattern_ch
   import ref_pattern_pkg::*;
#(
   parameter int CH_IDX = 0
) (
   input  logic       CLK,
   input  logic       RST_B,
   input  logic       EN,
   input  logic [2:0] MODE,
   input  logic       toggle_bit,
   input  logic       pulse_hit,
   input  logic       square_hit,
   output logic       dat
);

   localparam logic [PRBS_W-1:0] SEED = prbs_seed(CH_IDX);

   logic [PRBS_W-1:0] lfsr;
   logic              sel;

   // NOTE: give every always_comb output a default first so no path leaves it unassigned (that would infer a latch).
   always_comb begin
      sel = 1'b0;
      case (mode_e'(MODE))
         MODE_ONE:    sel = 1'b1;
         MODE_TOGGLE: sel = toggle_bit;
         MODE_PULSE:  sel = pulse_hit;
         MODE_PRBS:   sel = lfsr[PRBS_OUT_BIT];
         MODE_SQUARE: sel = square_hit;
         default:     sel = 1'b0;
      endcase
   end

   // The LFSR steps on every enabled cycle whatever MODE says, keeping channels phase-aligned.
   always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
         lfsr <= SEED;
         dat  <= 1'b0;
      end else if (!EN) begin
         lfsr <= SEED;
         dat  <= 1'b0;
      end else begin
         lfsr <= prbs_next(lfsr);
         dat  <= sel;
      end
   end

endmodule

// File: rtl/ref_pattern_gen.sv
// Multi-channel reference pattern generator: shared period counter, toggle and
// wrap strobe driving N_CH independent pattern channels.
module ref_pattern_gen
   import ref_pattern_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CNT_W = 17
) (
   input  logic                CLK,
   input  logic                RST_B,
   input  logic                EN,
   input  logic [3*N_CH-1:0]   MODE,
   input  logic [CNT_W-1:0]    PERIOD,
   input  logic [CNT_W-1:0]    PULSE_POS,
   output logic [N_CH-1:0]     DAT_OUT,
   output logic                WRAP
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] terminal;
   logic             toggle;
   logic             at_end;
   logic             pulse_hit;
   logic             square_hit;

   // PERIOD 0 and 1 both collapse to a one-cycle frame; >= also catches a PERIOD lowered below cnt.
   assign terminal   = (PERIOD <= CNT_W'(1)) ? '0 : PERIOD - CNT_W'(1);
   assign at_end     = (cnt >= terminal);
   assign pulse_hit  = (cnt == PULSE_POS);
   assign square_hit = (cnt < (PERIOD >> 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
         cnt    <= '0;
         toggle <= 1'b0;
         WRAP   <= 1'b0;
      end else if (!EN) begin
         cnt    <= '0;
         toggle <= 1'b0;
         WRAP   <= 1'b0;
      end else begin
         cnt    <= at_end ? '0 : cnt + CNT_W'(1);
         toggle <= ~toggle;
         WRAP   <= at_end;
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      ref_pattern_ch #(
         .CH_IDX(k)
      ) u_ch (
         .CLK        (CLK),
         .RST_B      (RST_B),
         .EN         (EN),
         .MODE       (MODE[3*k +: 3]),
         .toggle_bit (~toggle),
         .pulse_hit  (pulse_hit),
         .square_hit (square_hit),
         .dat        (DAT_OUT[k])
      );
   end

endmodule

// File: doc/ref_pattern_gen.md
REF_PATTERN_GEN -- requirements
Module: ref_pattern_gen

Interface
REQ-001 Parameter N_CH, default 4: number of independent reference channels, legal range 1..16.
REQ-002 Parameter CNT_W, default 17: width of the period counter, PERIOD and PULSE_POS.
REQ-003 CLK  input  1: single clock; all state changes on its rising edge.
REQ-004 RST_B  input  1: asynchronous, active-low reset.
REQ-005 EN  input  1: run enable; low = synchronous restart (REQ-016).
REQ-006 MODE  input  3*N_CH: per-channel mode; channel k uses bits [3k+2:3k].
REQ-007 PERIOD  input  CNT_W: frame length in cycles; counter terminal value is PERIOD-1.
REQ-008 PULSE_POS  input  CNT_W: counter value at which pulse mode asserts.
REQ-009 DAT_OUT  output  N_CH: registered reference bit per channel.
REQ-010 WRAP  output  1: registered one-cycle strobe, high in the cycle after the counter wraps.

Function
REQ-011 Period counter: while EN=1, increments by 1 per cycle; loads 0 when value >= PERIOD-1; carries no overflow state.
REQ-012 PERIOD 0 and 1 both mean a 1-cycle frame: counter holds 0; WRAP high every enabled cycle.
REQ-013 PERIOD lowered mid-frame below the current count: counter loads 0 on the next edge (>= compare), no aliasing through 2^CNT_W.
REQ-014 Mode encodings:
- 000 = constant 0
- 001 = constant 1
- 010 = half-rate toggle (0,1,0,1... starting at 1 on the first enabled cycle)
- 011 = single pulse, high when the counter equals PULSE_POS
- 100 = PRBS7 (x^7+x^6+1), output = LFSR bit 6
- 101 = frame square wave, high while counter < PERIOD/2 (integer floor)
- 110/111 = reserved, drive 0
REQ-015 Latency: DAT_OUT and WRAP are registered; each reflects counter/LFSR/toggle state with exactly 1 cycle latency; no combinational path from any input to any output.
REQ-016 EN low: on the next edge counter=0, toggle=0, every LFSR reloads its seed, DAT_OUT=0, WRAP=0; the first enabled cycle after EN rises behaves exactly as the first cycle after reset release.
REQ-017 PRBS seed for channel k = 7'(k+1); LFSR advances once per enabled cycle regardless of that channel's MODE, so mode switches keep channels phase-aligned.
REQ-018 PULSE_POS >= max(PERIOD,1): pulse mode never asserts; no error flagged.
REQ-019 MODE change takes effect on DAT_OUT on the next edge; counter, toggle and LFSR state are not disturbed.
REQ-020 PERIOD/PULSE_POS are sampled every cycle; quasi-static use is the caller's responsibility; no internal synchronisation.

Reset
REQ-021 RST_B low asynchronously forces counter=0, toggle=0, LFSRs=seeds, DAT_OUT=0, WRAP=0.
REQ-022 Reset release is sampled on CLK; the first rising edge with RST_B=1 and EN=1 is cycle 0 of frame 0.
REQ-023 Reset asserted mid-frame discards all state; no partial-frame recovery.

Structure
REQ-024 Shared package ref_pattern_pkg holds the MODE encodings, PRBS7 tap positions, and the seed function.
REQ-025 One sub-module ref_pattern_ch (per-channel LFSR, mode mux, output register) is instantiated N_CH times by a generate loop; the period counter, toggle and WRAP are shared in the top module.

Verification
REQ-026 Reset, EN=1, MODE all 010: DAT_OUT = 0 in reset, then 1,0,1,0... from the first post-release edge +1 cycle on every channel.
REQ-027 PERIOD=10000, PULSE_POS=99, MODE=011: DAT_OUT high for exactly one cycle, 100 cycles after frame start, repeating every 10000 cycles; WRAP every 10000 cycles.
REQ-028 MODE=100 on ch0 (seed 1): the first 127 outputs match a golden PRBS7 model, the sequence repeats at 127, and all-zero state is never reached.
REQ-029 PERIOD=8, MODE=101: DAT_OUT 1111 0000 repeating; then PERIOD changed to 3 at count 6 -> counter 0 next edge, pattern 1,0,0 thereafter.
REQ-030 EN dropped for 5 cycles mid-frame, then raised: DAT_OUT/WRAP 0 during the low period; post-restart outputs bit-identical to the post-reset trace of REQ-026/028.
REQ-031 PERIOD=0, PULSE_POS=0, MODE=011: DAT_OUT and WRAP high every enabled cycle; PULSE_POS=5 -> DAT_OUT stays 0.
